seq_calc_unit: RTL and testbench
================================

// Module: seq_calc_unit
// PURPOSE
//  Parametrised, handshaked arithmetic unit: one operation (add/sub/mul/div)
//  accepted per request, selected by i_op. Add/sub/mul complete in 1 cycle;
//  divide runs a multi-cycle restoring divider that also returns the remainder.
//  Sits between an operand-issuing controller and a result register/display stage.
// PARAMETERS
//  WIDTH   6   operand width in bits (legal range 2..16)
// PORTS
//  clk       in   1          clock, rising edge
//  rstb      in   1          asynchronous, active-low reset
//  i_valid   in   1          request strobe; accepted only when o_ready=1
//  i_op      in   2          00=add 01=sub 10=mul 11=div
//  i_data1   in   WIDTH      operand A (unsigned)
//  i_data2   in   WIDTH      operand B (unsigned)
//  o_ready   out  1          unit idle, can accept a request this cycle
//  o_valid   out  1          one-cycle pulse: o_result/o_rem/o_dz valid
//  o_result  out  2*WIDTH    result, zero-extended into 2*WIDTH
//  o_rem     out  WIDTH      division remainder; 0 for non-div ops
//  o_dz      out  1          divide-by-zero flag, valid with o_valid
// BEHAVIOUR
//  - Reset: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_rem=0, o_dz=0.
//  - Accept = i_valid & o_ready; operands and op are registered at accept.
//  - FSM: IDLE -> (accept, op!=div or B==0) DONE; IDLE -> (accept, div, B!=0) DIV;
//    DIV -> DONE after WIDTH iterations; DONE -> IDLE unconditionally.
//  - o_ready=1 only in IDLE; i_valid outside IDLE is ignored (not queued).
//  - o_valid=1 only in DONE (exactly one cycle); o_result/o_rem/o_dz hold their
//    values until the next DONE.
//  - Latency accept->o_valid: add/sub/mul/div-by-zero = 1 cycle; div = WIDTH+1.
//  - Back-to-back: new accept possible the cycle after o_valid (IDLE).
//  - add: WIDTH+1-bit sum, upper bits zero.
//  - sub: (A-B) mod 2^(WIDTH+1); bit WIDTH = borrow; upper bits zero.
//  - mul: full 2*WIDTH-bit product.
//  - div: restoring, one quotient bit per cycle MSB first; quotient in
//    o_result[WIDTH-1:0], remainder in o_rem; A<B gives q=0, rem=A.
//  - div with B==0: o_result = all-ones in [WIDTH-1:0], o_rem = A, o_dz=1.
//    o_dz=0 for all other results.
//  - o_rem=0 for add/sub/mul.
//  - Reset asserted mid-division: abort, return to reset state, no o_valid.
//  - Iteration counter width = clog2(WIDTH+1); no wrap inside DIV.
// CONFIGURATION
//  SEQ_CALC_SUB_SAT_EN defined: sub saturates; if B>A, o_result=0 (no wrap).
//  Not defined: sub wraps mod 2^(WIDTH+1) as above. All other ops unaffected.
// TESTING (WIDTH=6)
//  add 63+63 -> o_valid 1 cycle after accept, o_result=126, o_rem=0, o_dz=0
//  sub 5-9 -> o_result=124 (0x7C); with SEQ_CALC_SUB_SAT_EN o_result=0
//  mul 63*63 -> o_result=3969; i_valid held high gives accept every 2 cycles
//  div 45/7 -> o_ready low 7 cycles, o_valid at accept+7, q=6, o_rem=3;
//    i_valid pulses during DIV ignored
//  div 17/0 -> o_valid at accept+1, o_result=63, o_rem=17, o_dz=1
//  div 60/4, rstb low at accept+3 -> all outputs 0, o_ready=1, no o_valid

Source files
------------

// File: rtl/seq_calc_unit.sv
// Handshaked add/sub/mul/div unit; divide is a WIDTH-cycle restoring divider.
// Optional macro SEQ_CALC_SUB_SAT_EN: subtract saturates at zero instead of wrapping.
module seq_calc_unit #(
   parameter int WIDTH = 6
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               i_valid,
   input  logic [1:0]         i_op,
   input  logic [WIDTH-1:0]   i_data1,
   input  logic [WIDTH-1:0]   i_data2,
   output logic               o_ready,
   output logic               o_valid,
   output logic [2*WIDTH-1:0] o_result,
   output logic [WIDTH-1:0]   o_rem,
   output logic               o_dz
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic               accept;
   logic               last;
   logic               div_go;
   logic               b_zero;

   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   part;
   logic [CW-1:0]      cnt;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] fast_res;

   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;
   logic               fits;
   logic [WIDTH-1:0]   part_nx;
   logic [WIDTH-1:0]   quo_nx;

   assign b_zero = (i_data2 == '0);
   assign div_go = (i_op == OP_DIV) && !b_zero;

   // Single-cycle results computed straight from the request operands
   always_comb begin
      sum      = {1'b0, i_data1} + {1'b0, i_data2};
      diff     = {1'b0, i_data1} - {1'b0, i_data2};
`ifdef SEQ_CALC_SUB_SAT_EN
      if (i_data2 > i_data1) begin
         diff = '0;
      end
`endif
      prod     = {{WIDTH{1'b0}}, i_data1} * {{WIDTH{1'b0}}, i_data2};
      fast_res = '0;
      unique case (i_op)
         OP_ADD:  fast_res = {{(WIDTH-1){1'b0}}, sum};
         OP_SUB:  fast_res = {{(WIDTH-1){1'b0}}, diff};
         OP_MUL:  fast_res = prod;
         default: fast_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
      endcase
   end

   // One restoring-division step: shift in next dividend bit, try subtract
   always_comb begin
      shifted = {part, quo[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      fits    = (shifted >= {1'b0, divisor});
      part_nx = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_nx  = {quo[WIDTH-2:0], fits};
   end

   // State register
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_nx = state;
      o_ready  = 1'b0;
      o_valid  = 1'b0;
      accept   = 1'b0;
      last     = 1'b0;
      unique case (state)
         IDLE: begin
            o_ready = 1'b1;
            accept  = i_valid;
            if (i_valid) begin
               state_nx = div_go ? DIV : DONE;
            end
         end
         DIV: begin
            last = (cnt == CW'(WIDTH - 1));
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            o_valid  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, divider iteration and result registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         divisor  <= '0;
         quo      <= '0;
         part     <= '0;
         cnt      <= '0;
         o_result <= '0;
         o_rem    <= '0;
         o_dz     <= 1'b0;
      end else if (accept) begin
         divisor <= i_data2;
         quo     <= i_data1;
         part    <= '0;
         cnt     <= '0;
         if (i_op != OP_DIV) begin
            o_result <= fast_res;
            o_rem    <= '0;
            o_dz     <= 1'b0;
         end else if (b_zero) begin
            o_result <= fast_res;
            o_rem    <= i_data1;
            o_dz     <= 1'b1;
         end
      end else if (state == DIV) begin
         part <= part_nx;
         quo  <= quo_nx;
         cnt  <= cnt + CW'(1);
         if (last) begin
            o_result <= {{WIDTH{1'b0}}, quo_nx};
            o_rem    <= part_nx;
            o_dz     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_calc_unit.sv
// Directed bench for seq_calc_unit at WIDTH=6.
// Honours SEQ_CALC_SUB_SAT_EN for the subtract expectation.
module tb_seq_calc_unit;

   localparam int W = 6;

   logic           clk;
   logic           rstb;
   logic           i_valid;
   logic [1:0]     i_op;
   logic [W-1:0]   i_data1;
   logic [W-1:0]   i_data2;
   logic           o_ready;
   logic           o_valid;
   logic [2*W-1:0] o_result;
   logic [W-1:0]   o_rem;
   logic           o_dz;

   int checks = 0;
   int errors = 0;

   seq_calc_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .rstb     (rstb),
      .i_valid  (i_valid),
      .i_op     (i_op),
      .i_data1  (i_data1),
      .i_data2  (i_data2),
      .o_ready  (o_ready),
      .o_valid  (o_valid),
      .o_result (o_result),
      .o_rem    (o_rem),
      .o_dz     (o_dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [1:0] op,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b);
      i_valid = 1'b1;
      i_op    = op;
      i_data1 = a;
      i_data2 = b;
   endtask

   initial begin
      logic seen;
      logic [2*W-1:0] sub_exp;
      rstb    = 1'b0;
      i_valid = 1'b0;
      i_op    = 2'b00;
      i_data1 = '0;
      i_data2 = '0;
      tick();
      check("rst_ready", o_ready, 1);
      check("rst_valid", o_valid, 0);
      check("rst_result", o_result, 0);
      check("rst_rem", o_rem, 0);
      check("rst_dz", o_dz, 0);
      tick();
      rstb = 1'b1;
      tick();

      // add 63+63
      req(2'b00, 63, 63);
      tick();
      i_valid = 1'b0;
      check("add_valid", o_valid, 1);
      check("add_ready", o_ready, 0);
      check("add_result", o_result, 126);
      check("add_rem", o_rem, 0);
      check("add_dz", o_dz, 0);
      tick();
      check("add_valid_drop", o_valid, 0);
      check("add_ready_back", o_ready, 1);
      check("add_hold", o_result, 126);

      // sub 5-9 (borrow) and 9-5
`ifdef SEQ_CALC_SUB_SAT_EN
      sub_exp = 0;
`else
      sub_exp = 124;
`endif
      req(2'b01, 5, 9);
      tick();
      i_valid = 1'b0;
      check("sub_borrow_valid", o_valid, 1);
      check("sub_borrow", o_result, sub_exp);
      tick();
      req(2'b01, 9, 5);
      tick();
      i_valid = 1'b0;
      check("sub_plain", o_result, 4);
      tick();

      // mul with i_valid held: accept every 2 cycles
      req(2'b10, 63, 63);
      tick();
      check("mul_valid", o_valid, 1);
      check("mul_result", o_result, 3969);
      check("mul_rem", o_rem, 0);
      i_data1 = 10;
      i_data2 = 20;
      tick();
      check("mul_gap_valid", o_valid, 0);
      check("mul_gap_ready", o_ready, 1);
      tick();
      i_valid = 1'b0;
      check("mul2_valid", o_valid, 1);
      check("mul2_result", o_result, 200);
      tick();

      // div 45/7 with ignored pulses during DIV
      req(2'b11, 45, 7);
      tick();
      check("div_hold_result", o_result, 200);
      for (int i = 0; i < 6; i++) begin
         check("div_busy", {o_ready, o_valid}, 2'b00);
         i_valid = (i < 5) ? i[0] : 1'b0;
         i_op    = 2'b00;
         i_data1 = 1;
         i_data2 = 1;
         tick();
      end
      i_valid = 1'b0;
      check("div_valid", o_valid, 1);
      check("div_q", o_result, 6);
      check("div_rem", o_rem, 3);
      check("div_dz", o_dz, 0);
      tick();
      check("div_ready_back", o_ready, 1);
      check("div_no_extra", o_valid, 0);

      // div 5/9: A<B
      req(2'b11, 5, 9);
      tick();
      i_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen = seen | o_valid;
         tick();
      end
      check("div_small_early", seen, 0);
      check("div_small_valid", o_valid, 1);
      check("div_small_q", o_result, 0);
      check("div_small_rem", o_rem, 5);
      tick();

      // add clears remainder
      req(2'b00, 1, 2);
      tick();
      i_valid = 1'b0;
      check("add2_result", o_result, 3);
      check("add2_rem", o_rem, 0);
      tick();

      // div 17/0
      req(2'b11, 17, 0);
      tick();
      i_valid = 1'b0;
      check("dz_valid", o_valid, 1);
      check("dz_result", o_result, 63);
      check("dz_rem", o_rem, 17);
      check("dz_flag", o_dz, 1);
      tick();

      // div 60/4 aborted by reset at accept+3
      req(2'b11, 60, 4);
      tick();
      i_valid = 1'b0;
      tick();
      tick();
      rstb = 1'b0;
      #1;
      check("abort_result", o_result, 0);
      check("abort_rem", o_rem, 0);
      check("abort_dz", o_dz, 0);
      check("abort_ready", o_ready, 1);
      check("abort_valid", o_valid, 0);
      tick();
      rstb = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen = seen | o_valid;
         tick();
      end
      check("abort_no_valid", seen, 0);
      check("abort_idle", o_ready, 1);

      // dz flag cleared by a later non-div op
      req(2'b11, 17, 0);
      tick();
      i_valid = 1'b0;
      check("dz2_flag", o_dz, 1);
      tick();
      req(2'b00, 1, 2);
      tick();
      i_valid = 1'b0;
      check("dz_clear", o_dz, 0);
      check("dz_clear_rem", o_rem, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
